// File: rtl/scene_render_pkg.sv
// rtl/scene_render_pkg.sv - raster geometry, palette, pipeline records and CRC helper for scene_renderer.
package scene_render_pkg;

   localparam int H_ACTIVE      = 800;
   localparam int H_FP          = 40;
   localparam int H_SYNC        = 128;
   localparam int H_BP          = 88;
   localparam int V_ACTIVE      = 480;
   localparam int V_FP          = 13;
   localparam int V_SYNC        = 3;
   localparam int V_BP          = 29;
   localparam int GROUND_X      = 104;
   localparam int STRIPE_PERIOD = 28;
   localparam int PIPE_W        = 52;
   localparam int GAP_NEAR      = 80;
   localparam int GAP_FAR       = 220;
   localparam int BIRD_W        = 34;
   localparam int BIRD_H        = 24;

   function automatic int h_total();
      return H_ACTIVE + H_FP + H_SYNC + H_BP;
   endfunction

   function automatic int v_total();
      return V_ACTIVE + V_FP + V_SYNC + V_BP;
   endfunction

   localparam int H_TOTAL = h_total();
   localparam int V_TOTAL = v_total();

   localparam logic [11:0] SKY      = 12'h7CF;
   localparam logic [11:0] GROUND_A = 12'hDB6;
   localparam logic [11:0] GROUND_B = 12'hCA5;
   localparam logic [11:0] PIPE     = 12'h5B3;
   localparam logic [11:0] BIRD_0   = 12'hFD2;
   localparam logic [11:0] BIRD_1   = 12'hFB1;
   localparam logic [11:0] BIRD_2   = 12'hF91;

   typedef enum logic [1:0] {HIT_SKY, HIT_GROUND, HIT_PIPE, HIT_BIRD} hit_e;

   typedef struct packed {
      logic [15:0]       stage_shift;
      logic [1:0]        bird_status;
      logic [15:0]       bird_x;
      logic [15:0]       bird_y;
      logic [2:0][15:0]  pipe_x;
      logic [2:0][15:0]  pipe_y;
   } shadow_t;

   typedef struct packed {
      logic [10:0] h;
      logic [9:0]  v;
      logic        hs;
      logic        vs;
      logic        de;
   } s1_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic ground;
      logic pipe;
      logic bird;
      logic stripe_a;
   } s2_t;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] rgb;
   } s3_t;

   function automatic logic signed [16:0] sx17(input logic [15:0] x);
      return {x[15], x};
   endfunction

   // CRC-16-CCITT, 12 data bits shifted in MSB first.
   function automatic logic [15:0] crc16_12(input logic [15:0] crc_in, input logic [11:0] data);
      logic [15:0] c;
      c = crc_in;
      for (int i = 11; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/scene_renderer_if.sv
// rtl/scene_renderer_if.sv - game-state bus from game logic to the renderer, with new_frame handshake back.
interface scene_renderer_if;
   import scene_render_pkg::*;

   logic [15:0] stage_shift;
   logic [1:0]  bird_status;
   logic [15:0] bird_pos_x;
   logic [15:0] bird_pos_y;
   logic [15:0] pipe1_pos_x;
   logic [15:0] pipe2_pos_x;
   logic [15:0] pipe3_pos_x;
   logic [15:0] pipe1_pos_y;
   logic [15:0] pipe2_pos_y;
   logic [15:0] pipe3_pos_y;
   logic        new_frame;

   modport master (
      output stage_shift, bird_status, bird_pos_x, bird_pos_y,
             pipe1_pos_x, pipe2_pos_x, pipe3_pos_x,
             pipe1_pos_y, pipe2_pos_y, pipe3_pos_y,
      input  new_frame
   );

   modport slave (
      input  stage_shift, bird_status, bird_pos_x, bird_pos_y,
             pipe1_pos_x, pipe2_pos_x, pipe3_pos_x,
             pipe1_pos_y, pipe2_pos_y, pipe3_pos_y,
      output new_frame
   );

endinterface

// File: rtl/scan_timing.sv
// rtl/scan_timing.sv - raster h/v counters, raw sync/enable, new_frame strobe and end-of-frame snapshot strobe.
module scan_timing
   import scene_render_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   output logic [10:0] h,
   output logic [9:0]  v,
   output logic        hsync_raw,
   output logic        vsync_raw,
   output logic        de_raw,
   output logic        new_frame,
   output logic        snap
);

   logic [10:0] h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic        new_frame_q, new_frame_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         h_q         <= '0;
         v_q         <= '0;
         new_frame_q <= 1'b0;
      end else begin
         h_q         <= h_d;
         v_q         <= v_d;
         new_frame_q <= new_frame_d;
      end
   end

   always_comb begin
      h_d = h_q + 11'd1;
      v_d = v_q;
      if (h_q == 11'(H_TOTAL - 1)) begin
         h_d = '0;
         v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
      end
      // Taken straight from the counters so game logic gets the whole blank.
      new_frame_d = (h_q == '0) && (v_q == 10'(V_ACTIVE));
   end

   assign h         = h_q;
   assign v         = v_q;
   assign hsync_raw = !((h_q >= 11'(H_ACTIVE + H_FP)) && (h_q < 11'(H_ACTIVE + H_FP + H_SYNC)));
   assign vsync_raw = !((v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC)));
   assign de_raw    = (h_q < 11'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
   assign new_frame = new_frame_q;
   assign snap      = (h_q == 11'(H_TOTAL - 1)) && (v_q == 10'(V_TOTAL - 1));

endmodule

// File: rtl/scene_renderer.sv
// rtl/scene_renderer.sv - per-frame game-state snapshot and 3-stage sky/ground/pipe/bird compositor.
// Optional frame CRC output enabled by SCENE_FRAME_CRC_EN.
module scene_renderer
   import scene_render_pkg::*;
(
   input  logic            clk,
   input  logic            rstn,
   scene_renderer_if.slave gs,
   output logic            hsync,
   output logic            vsync,
   output logic            de,
   output logic [11:0]     rgb
`ifdef SCENE_FRAME_CRC_EN
   ,
   output logic [15:0]     frame_crc
`endif
);

   localparam logic signed [16:0] GROUND_X_S = 17'(GROUND_X);
   localparam logic signed [16:0] PIPE_W_S   = 17'(PIPE_W);
   localparam logic signed [16:0] GAP_NEAR_S = 17'(GAP_NEAR);
   localparam logic signed [16:0] GAP_FAR_S  = 17'(GAP_FAR);
   localparam logic signed [16:0] BIRD_W_S   = 17'(BIRD_W);
   localparam logic signed [16:0] BIRD_H_S   = 17'(BIRD_H);

   logic [10:0] h_raw;
   logic [9:0]  v_raw;
   logic        hs_raw, vs_raw, de_raw, snap;

   shadow_t shadow_q, shadow_d;
   s1_t     s1_q, s1_d;
   s2_t     s2_q, s2_d;
   s3_t     s3_q, s3_d;

   logic signed [16:0] hs17, vs17, px, py, bx, by;
   logic [16:0]        stripe_r;
   logic               pipe_hit;
   hit_e               cls;
   logic [11:0]        colour;

   scan_timing u_timing (
      .clk       (clk),
      .rstn      (rstn),
      .h         (h_raw),
      .v         (v_raw),
      .hsync_raw (hs_raw),
      .vsync_raw (vs_raw),
      .de_raw    (de_raw),
      .new_frame (gs.new_frame),
      .snap      (snap)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         shadow_q <= '0;
         s1_q     <= '{h: '0, v: '0, hs: 1'b1, vs: 1'b1, de: 1'b0};
         s2_q     <= '{hs: 1'b1, vs: 1'b1, de: 1'b0, ground: 1'b0, pipe: 1'b0, bird: 1'b0, stripe_a: 1'b0};
         s3_q     <= '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: '0};
      end else begin
         shadow_q <= shadow_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s3_q     <= s3_d;
      end
   end

   always_comb begin
      shadow_d = shadow_q;
      if (snap) begin
         shadow_d.stage_shift = gs.stage_shift;
         shadow_d.bird_status = gs.bird_status;
         shadow_d.bird_x      = gs.bird_pos_x;
         shadow_d.bird_y      = gs.bird_pos_y;
         shadow_d.pipe_x      = {gs.pipe3_pos_x, gs.pipe2_pos_x, gs.pipe1_pos_x};
         shadow_d.pipe_y      = {gs.pipe3_pos_y, gs.pipe2_pos_y, gs.pipe1_pos_y};
      end

      s1_d = '{h: h_raw, v: v_raw, hs: hs_raw, vs: vs_raw, de: de_raw};

      hs17 = $signed({6'b0, s1_q.h});
      vs17 = $signed({7'b0, s1_q.v});

      // Row + shift never exceeds 506, so binary-weighted subtraction replaces a divider.
      stripe_r = 17'(vs17 + sx17(shadow_q.stage_shift));
      for (int k = 4; k >= 0; k--) begin
         if (stripe_r >= (17'(STRIPE_PERIOD) << k)) stripe_r = stripe_r - (17'(STRIPE_PERIOD) << k);
      end

      px       = '0;
      py       = '0;
      pipe_hit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         px = sx17(shadow_q.pipe_x[i]);
         py = sx17(shadow_q.pipe_y[i]);
         if ((vs17 >= py) && (vs17 < py + PIPE_W_S) && (hs17 >= GROUND_X_S) &&
             !((hs17 >= px - GAP_FAR_S) && (hs17 <= px - GAP_NEAR_S)))
            pipe_hit = 1'b1;
      end

      bx = sx17(shadow_q.bird_x);
      by = sx17(shadow_q.bird_y);
      s2_d = '{hs: s1_q.hs, vs: s1_q.vs, de: s1_q.de,
               ground:   hs17 < GROUND_X_S,
               pipe:     pipe_hit,
               bird:     (hs17 >= bx) && (hs17 < bx + BIRD_W_S) && (vs17 >= by) && (vs17 < by + BIRD_H_S),
               stripe_a: stripe_r < 17'(STRIPE_PERIOD / 2)};

      cls = s2_q.bird ? HIT_BIRD : s2_q.pipe ? HIT_PIPE : s2_q.ground ? HIT_GROUND : HIT_SKY;
      case (cls)
         HIT_BIRD: begin
            case (shadow_q.bird_status)
               2'b00:   colour = BIRD_0;
               2'b10:   colour = BIRD_2;
               default: colour = BIRD_1;
            endcase
         end
         HIT_PIPE:   colour = PIPE;
         HIT_GROUND: colour = s2_q.stripe_a ? GROUND_A : GROUND_B;
         default:    colour = SKY;
      endcase
      s3_d = '{hs: s2_q.hs, vs: s2_q.vs, de: s2_q.de, rgb: s2_q.de ? colour : 12'h000};
   end

   assign hsync = s3_q.hs;
   assign vsync = s3_q.vs;
   assign de    = s3_q.de;
   assign rgb   = s3_q.rgb;

`ifdef SCENE_FRAME_CRC_EN
   logic        last2_q, last2_d, last3_q, last3_d;
   logic [15:0] crc_acc_q, crc_acc_d, frame_crc_q, frame_crc_d, crc_next;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         last2_q     <= 1'b0;
         last3_q     <= 1'b0;
         crc_acc_q   <= 16'hFFFF;
         frame_crc_q <= '0;
      end else begin
         last2_q     <= last2_d;
         last3_q     <= last3_d;
         crc_acc_q   <= crc_acc_d;
         frame_crc_q <= frame_crc_d;
      end
   end

   always_comb begin
      last2_d     = (s1_q.h == 11'(H_ACTIVE - 1)) && (s1_q.v == 10'(V_ACTIVE - 1));
      last3_d     = last2_q;
      crc_next    = crc16_12(crc_acc_q, s3_q.rgb);
      crc_acc_d   = crc_acc_q;
      frame_crc_d = frame_crc_q;
      if (s3_q.de) begin
         if (last3_q) begin
            frame_crc_d = crc_next;
            crc_acc_d   = 16'hFFFF;
         end else begin
            crc_acc_d   = crc_next;
         end
      end
   end

   assign frame_crc = frame_crc_q;
`endif

endmodule

// File: tb/tb_scene_renderer.sv
// tb/tb_scene_renderer.sv - directed self-checking bench for scene_renderer.
module tb_scene_renderer;

   localparam int HT    = 1056;
   localparam int VT    = 525;
   localparam int FRAME = HT * VT;
   localparam int FIRST_NF = 480 * HT + 1;

   localparam logic [11:0] C_SKY = 12'h7CF;
   localparam logic [11:0] C_GA  = 12'hDB6;
   localparam logic [11:0] C_GB  = 12'hCA5;
   localparam logic [11:0] C_PIP = 12'h5B3;
   localparam logic [11:0] C_B0  = 12'hFD2;
   localparam logic [11:0] C_B1  = 12'hFB1;
   localparam logic [11:0] C_B2  = 12'hF91;

   typedef struct packed {
      logic [10:0] h;
      logic [9:0]  v;
      logic [11:0] c;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        hsync, vsync, de;
   logic [11:0] rgb;
`ifdef SCENE_FRAME_CRC_EN
   logic [15:0] frame_crc;
`endif

   int     checks = 0;
   int     passed = 0;
   int     pos = 0;
   longint cyc = 0;
   longint t_nf1 = 0;

   always #5 clk = ~clk;

   scene_renderer_if gs ();

   scene_renderer dut (
      .clk   (clk),
      .rstn  (rstn),
      .gs    (gs),
      .hsync (hsync),
      .vsync (vsync),
      .de    (de),
      .rgb   (rgb)
`ifdef SCENE_FRAME_CRC_EN
      ,
      .frame_crc (frame_crc)
`endif
   );

   // Raster position of the counters as defined for the panel: edges since reset release.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rstn) pos <= 0;
      else       pos <= (pos + 1) % FRAME;
   end

   task automatic wait_pixel(input int h, input int v, output bit ok);
      int target;
      target = (v * HT + h + 3) % FRAME;
      ok = 1'b0;
      for (int n = 0; n < FRAME + 10; n++) begin
         @(negedge clk);
         if (pos == target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      gs.stage_shift = 16'd13;
      gs.bird_status = 2'b10;
      gs.bird_pos_x  = 16'd400;
      gs.bird_pos_y  = 16'd240;
      gs.pipe1_pos_x = 16'd500;
      gs.pipe2_pos_x = 16'd500;
      gs.pipe3_pos_x = 16'd500;
      gs.pipe1_pos_y = -16'sd120;
      gs.pipe2_pos_y = -16'sd120;
      gs.pipe3_pos_y = -16'sd120;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (hsync !== 1'b1) $display("FAIL reset hsync: got %b expected 1", hsync); else passed++;
      checks++; if (vsync !== 1'b1) $display("FAIL reset vsync: got %b expected 1", vsync); else passed++;
      checks++; if (de !== 1'b0) $display("FAIL reset de: got %b expected 0", de); else passed++;
      checks++; if (rgb !== 12'h000) $display("FAIL reset rgb: got %h expected 000", rgb); else passed++;
      checks++; if (gs.new_frame !== 1'b0) $display("FAIL reset new_frame: got %b expected 0", gs.new_frame); else passed++;
      rstn = 1'b1;
   endtask

   task automatic test_line_timing();
      bit ok;
      int hs_low, de_high;
      hs_low = 0;
      de_high = 0;
      wait_pixel(0, 10, ok);
      for (int n = 0; n < HT; n++) begin
         if (n != 0) @(negedge clk);
         if (hsync === 1'b0) hs_low++;
         if (de === 1'b1) de_high++;
      end
      checks++; if (!ok || hs_low != 128) $display("FAIL line hsync_low: got %0d expected 128", hs_low); else passed++;
      checks++; if (!ok || de_high != 800) $display("FAIL line de_high: got %0d expected 800", de_high); else passed++;
   endtask

   task automatic test_new_frame_first();
      bit found;
      found = 1'b0;
      for (int n = 0; n < FRAME + 10; n++) begin
         @(negedge clk);
         if (gs.new_frame === 1'b1) begin found = 1'b1; break; end
      end
      t_nf1 = cyc;
      checks++;
      if (!found) $display("FAIL first new_frame: timeout");
      else if (pos != FIRST_NF) $display("FAIL first new_frame delay: got %0d expected %0d", pos, FIRST_NF);
      else passed++;
      @(negedge clk);
      checks++; if (gs.new_frame !== 1'b0) $display("FAIL first new_frame width: got %b expected 0", gs.new_frame); else passed++;
   endtask

   task automatic test_stripes();
      vec_t vecs [6];
      bit ok;
      vecs = '{'{11'd0, 10'd0, C_GA}, '{11'd0, 10'd13, C_GB}, '{11'd0, 10'd14, C_GB},
               '{11'd0, 10'd15, C_GA}, '{11'd0, 10'd28, C_GA}, '{11'd0, 10'd29, C_GB}};
      foreach (vecs[i]) begin
         wait_pixel(int'(vecs[i].h), int'(vecs[i].v), ok);
         checks++;
         if (!ok) $display("FAIL stripe pix(%0d,%0d): timeout", vecs[i].h, vecs[i].v);
         else if (rgb !== vecs[i].c)
            $display("FAIL stripe pix(%0d,%0d): got %h expected %h", vecs[i].h, vecs[i].v, rgb, vecs[i].c);
         else passed++;
      end
   endtask

   task automatic test_bird_midframe();
      vec_t vecs [11];
      bit ok;
      vecs = '{'{11'd600, 10'd220, C_SKY}, '{11'd399, 10'd240, C_SKY}, '{11'd400, 10'd240, C_B2},
               '{11'd433, 10'd240, C_B2},  '{11'd434, 10'd240, C_SKY}, '{11'd50, 10'd250, C_GA},
               '{11'd410, 10'd250, C_B2},  '{11'd450, 10'd250, C_SKY}, '{11'd400, 10'd263, C_B2},
               '{11'd400, 10'd264, C_SKY}, '{11'd610, 10'd290, C_SKY}};
      wait_pixel(0, 100, ok);
      gs.bird_pos_x  = 16'd600;
      gs.bird_pos_y  = 16'd280;
      gs.bird_status = 2'b11;
      gs.pipe2_pos_y = 16'd200;
      foreach (vecs[i]) begin
         wait_pixel(int'(vecs[i].h), int'(vecs[i].v), ok);
         checks++;
         if (!ok) $display("FAIL bird pix(%0d,%0d): timeout", vecs[i].h, vecs[i].v);
         else if (rgb !== vecs[i].c)
            $display("FAIL bird pix(%0d,%0d): got %h expected %h", vecs[i].h, vecs[i].v, rgb, vecs[i].c);
         else passed++;
      end
   endtask

   task automatic test_new_frame_period();
      bit found;
      found = 1'b0;
      for (int n = 0; n < FRAME + 10; n++) begin
         @(negedge clk);
         if (gs.new_frame === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) $display("FAIL new_frame period: timeout");
      else if (cyc - t_nf1 != longint'(FRAME)) $display("FAIL new_frame period: got %0d expected %0d", cyc - t_nf1, FRAME);
      else passed++;
      @(negedge clk);
      checks++; if (gs.new_frame !== 1'b0) $display("FAIL second new_frame width: got %b expected 0", gs.new_frame); else passed++;
   endtask

   task automatic test_pipe();
      vec_t vecs [16];
      bit ok;
      vecs = '{'{11'd600, 10'd199, C_SKY}, '{11'd600, 10'd200, C_PIP}, '{11'd100, 10'd220, C_GA},
               '{11'd104, 10'd220, C_PIP}, '{11'd260, 10'd220, C_PIP}, '{11'd279, 10'd220, C_PIP},
               '{11'd280, 10'd220, C_SKY}, '{11'd300, 10'd220, C_SKY}, '{11'd420, 10'd220, C_SKY},
               '{11'd421, 10'd220, C_PIP}, '{11'd600, 10'd220, C_PIP}, '{11'd410, 10'd250, C_SKY},
               '{11'd600, 10'd251, C_PIP}, '{11'd600, 10'd252, C_SKY}, '{11'd599, 10'd290, C_SKY},
               '{11'd610, 10'd290, C_B1}};
      foreach (vecs[i]) begin
         wait_pixel(int'(vecs[i].h), int'(vecs[i].v), ok);
         checks++;
         if (!ok) $display("FAIL pipe pix(%0d,%0d): timeout", vecs[i].h, vecs[i].v);
         else if (rgb !== vecs[i].c)
            $display("FAIL pipe pix(%0d,%0d): got %h expected %h", vecs[i].h, vecs[i].v, rgb, vecs[i].c);
         else passed++;
      end
   endtask

   task automatic test_reset_midframe();
      vec_t   vecs [4];
      bit     ok, found;
      longint t_rel;
      vecs = '{'{11'd10, 10'd10, C_B0}, '{11'd40, 10'd10, C_GA}, '{11'd200, 10'd10, C_PIP},
               '{11'd50, 10'd30, C_GA}};
      wait_pixel(0, 300, ok);
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (!ok || hsync !== 1'b1) $display("FAIL midreset hsync: got %b expected 1", hsync); else passed++;
      checks++; if (vsync !== 1'b1) $display("FAIL midreset vsync: got %b expected 1", vsync); else passed++;
      checks++; if (de !== 1'b0) $display("FAIL midreset de: got %b expected 0", de); else passed++;
      checks++; if (rgb !== 12'h000) $display("FAIL midreset rgb: got %h expected 000", rgb); else passed++;
      checks++; if (gs.new_frame !== 1'b0) $display("FAIL midreset new_frame: got %b expected 0", gs.new_frame); else passed++;
      rstn = 1'b1;
      t_rel = cyc;
      foreach (vecs[i]) begin
         wait_pixel(int'(vecs[i].h), int'(vecs[i].v), ok);
         checks++;
         if (!ok) $display("FAIL postreset pix(%0d,%0d): timeout", vecs[i].h, vecs[i].v);
         else if (rgb !== vecs[i].c)
            $display("FAIL postreset pix(%0d,%0d): got %h expected %h", vecs[i].h, vecs[i].v, rgb, vecs[i].c);
         else passed++;
      end
      found = 1'b0;
      for (int n = 0; n < FRAME + 10; n++) begin
         @(negedge clk);
         if (gs.new_frame === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) $display("FAIL postreset new_frame: timeout");
      else if (cyc - t_rel != longint'(FIRST_NF))
         $display("FAIL postreset new_frame delay: got %0d expected %0d", cyc - t_rel, FIRST_NF);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_new_frame_first();
      test_stripes();
      test_bird_midframe();
      test_new_frame_period();
      test_pipe();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
